// File: rtl/serdes_bitslip_ctrl.sv
// serdes_bitslip_ctrl
// Word-alignment controller for an ISERDES/OSERDES pair. It resets the SERDES,
// lets it settle, then compares the incoming parallel word against a training
// pattern and issues BITSLIP pulses until the pattern is seen MATCH_COUNT times
// in a row (LOCKED) or every bit position has been tried (FAIL).
//
// Optional feature: define SERDES_ALIGN_MONITOR_EN to keep watching the data
// while LOCKED; LOSS_THRESH consecutive mismatches trigger automatic
// re-alignment. Without the macro, DATA_IN is ignored in LOCKED.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for START, SERDES held in reset
// SRST   | SERDES reset asserted for 4 cycles
// SETTLE | SERDES released, 8 cycles for the pipeline to fill
// CHECK  | comparing DATA_IN against the training word
// SLIP   | one-cycle BITSLIP pulse
// SWAIT  | hold-off after a slip while the ISERDES re-frames
// LOCKED | alignment achieved
// FAIL   | all DATA_WIDTH slip positions exhausted without a match run

module serdes_bitslip_ctrl #(
  parameter int         DATA_WIDTH    = 8,
  parameter logic [7:0] TRAIN_PATTERN = 8'h5C,
  parameter int         MATCH_COUNT   = 4,
  parameter int         SLIP_WAIT     = 3,
  parameter int         LOSS_THRESH   = 4
) (
  input  logic       CLKDIV,
  input  logic       RST,
  input  logic       START,
  input  logic [7:0] DATA_IN,
  output logic       SERDES_RST,
  output logic       BITSLIP,
  output logic       BUSY,
  output logic       LOCKED,
  output logic       FAIL,
  output logic [3:0] SLIP_COUNT
);

  // Out-of-range parameters are rejected at elaboration.
  if (DATA_WIDTH < 2 || DATA_WIDTH > 8) begin : g_bad_dw
    $error("DATA_WIDTH must be 2..8");
  end
  if (MATCH_COUNT < 1 || MATCH_COUNT > 15) begin : g_bad_mc
    $error("MATCH_COUNT must be 1..15");
  end
  if (SLIP_WAIT < 1 || SLIP_WAIT > 15) begin : g_bad_sw
    $error("SLIP_WAIT must be 1..15");
  end
  if (LOSS_THRESH < 1 || LOSS_THRESH > 15) begin : g_bad_lt
    $error("LOSS_THRESH must be 1..15");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SRST,
    S_SETTLE,
    S_CHECK,
    S_SLIP,
    S_SWAIT,
    S_LOCKED,
    S_FAIL
  } state_t;

  // Timers are down-counters loaded with (length - 1) and expire at zero.
  localparam logic [3:0] LP_SRST_M1   = 4'd3;
  localparam logic [3:0] LP_SETTLE_M1 = 4'd7;
  localparam logic [3:0] LP_SWAIT_M1  = 4'(SLIP_WAIT - 1);
  localparam logic [3:0] LP_DW        = 4'(DATA_WIDTH);
  localparam logic [3:0] LP_MC        = 4'(MATCH_COUNT);

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_timer;
  logic [3:0] w_timer_nxt;
  logic [3:0] r_match;
  logic [3:0] w_match_nxt;
  logic [3:0] r_slip;
  logic [3:0] w_slip_nxt;
  logic       w_match;
  logic       w_restart;

  logic       r_serdes_rst;
  logic       r_bitslip;
  logic       r_busy;
  logic       r_locked;
  logic       r_fail;

`ifdef SERDES_ALIGN_MONITOR_EN
  localparam logic [3:0] LP_LT_M1 = 4'(LOSS_THRESH - 1);
  logic [3:0] r_loss;
  logic [3:0] w_loss_nxt;
`endif

  assign w_match = (DATA_IN[DATA_WIDTH-1:0] == TRAIN_PATTERN[DATA_WIDTH-1:0]);

  // Next-state, timer and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_match_nxt = r_match;
    w_slip_nxt  = r_slip;
    w_restart   = 1'b0;
`ifdef SERDES_ALIGN_MONITOR_EN
    w_loss_nxt  = r_loss;
`endif
    case (r_state)
      S_IDLE: begin
        if (START) w_restart = 1'b1;
      end
      S_SRST: begin
        if (r_timer == 4'd0) begin
          w_state_nxt = S_SETTLE;
          w_timer_nxt = LP_SETTLE_M1;
        end else begin
          w_timer_nxt = r_timer - 4'd1;
        end
      end
      S_SETTLE: begin
        if (r_timer == 4'd0) begin
          w_state_nxt = S_CHECK;
          w_match_nxt = 4'd0;
        end else begin
          w_timer_nxt = r_timer - 4'd1;
        end
      end
      S_CHECK: begin
        // The run length is evaluated one cycle after the final match.
        if (r_match == LP_MC) begin
          w_state_nxt = S_LOCKED;
`ifdef SERDES_ALIGN_MONITOR_EN
          w_loss_nxt  = 4'd0;
`endif
        end else if (w_match) begin
          w_match_nxt = r_match + 4'd1;
        end else begin
          w_match_nxt = 4'd0;
          if (r_slip < LP_DW) begin
            w_state_nxt = S_SLIP;
            w_slip_nxt  = r_slip + 4'd1;
          end else begin
            w_state_nxt = S_FAIL;
          end
        end
      end
      S_SLIP: begin
        w_state_nxt = S_SWAIT;
        w_timer_nxt = LP_SWAIT_M1;
      end
      S_SWAIT: begin
        if (r_timer == 4'd0) begin
          w_state_nxt = S_CHECK;
        end else begin
          w_timer_nxt = r_timer - 4'd1;
        end
      end
      S_LOCKED: begin
        if (START) begin
          w_restart = 1'b1;
`ifdef SERDES_ALIGN_MONITOR_EN
        end else if (!w_match) begin
          if (r_loss == LP_LT_M1) begin
            w_restart = 1'b1;
          end else begin
            w_loss_nxt = r_loss + 4'd1;
          end
        end else begin
          w_loss_nxt = 4'd0;
`endif
        end
      end
      S_FAIL: begin
        if (START) w_restart = 1'b1;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_restart) begin
      w_state_nxt = S_SRST;
      w_timer_nxt = LP_SRST_M1;
      w_match_nxt = 4'd0;
      w_slip_nxt  = 4'd0;
`ifdef SERDES_ALIGN_MONITOR_EN
      w_loss_nxt  = 4'd0;
`endif
    end
  end

  // State and counter registers.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_timer <= 4'd0;
      r_match <= 4'd0;
      r_slip  <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_match <= w_match_nxt;
      r_slip  <= w_slip_nxt;
    end
  end

`ifdef SERDES_ALIGN_MONITOR_EN
  // Lock-loss mismatch run counter.
  always_ff @(posedge CLKDIV) begin
    if (RST) r_loss <= 4'd0;
    else     r_loss <= w_loss_nxt;
  end
`endif

  // Outputs are decoded from the next state and registered so they line up
  // with the state they describe and have no path from the inputs.
  always_ff @(posedge CLKDIV) begin
    if (RST) begin
      r_serdes_rst <= 1'b1;
      r_bitslip    <= 1'b0;
      r_busy       <= 1'b0;
      r_locked     <= 1'b0;
      r_fail       <= 1'b0;
    end else begin
      r_serdes_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_SRST);
      r_bitslip    <= (w_state_nxt == S_SLIP);
      r_busy       <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_LOCKED) &&
                      (w_state_nxt != S_FAIL);
      r_locked     <= (w_state_nxt == S_LOCKED);
      r_fail       <= (w_state_nxt == S_FAIL);
    end
  end

  assign SERDES_RST = r_serdes_rst;
  assign BITSLIP    = r_bitslip;
  assign BUSY       = r_busy;
  assign LOCKED     = r_locked;
  assign FAIL       = r_fail;
  assign SLIP_COUNT = r_slip;

endmodule

// File: tb/tb_serdes_bitslip_ctrl.sv
// Testbench for serdes_bitslip_ctrl: drives alignment scenarios, including a
// randomly rotated training stream that a small ISERDES model un-rotates by
// one bit per BITSLIP, and checks timing and status against expectations
// derived from the alignment rules.
module tb_serdes_bitslip_ctrl;

  localparam logic [7:0] P   = 8'h5C;
  localparam int         DW  = 8;
  localparam int         MC  = 4;
  localparam int         SW  = 3;

  logic       CLKDIV;
  logic       RST;
  logic       START;
  logic [7:0] DATA_IN;
  logic       SERDES_RST;
  logic       BITSLIP;
  logic       BUSY;
  logic       LOCKED;
  logic       FAIL;
  logic [3:0] SLIP_COUNT;

  int n_checks = 0;
  int n_pass   = 0;

  // ISERDES model: when mode is 1, DATA_IN is the training word rotated left
  // by 'off'; each BITSLIP rotates the framing back by one bit.
  int mode = 0;
  int off  = 0;

  serdes_bitslip_ctrl dut (
    .CLKDIV    (CLKDIV),
    .RST       (RST),
    .START     (START),
    .DATA_IN   (DATA_IN),
    .SERDES_RST(SERDES_RST),
    .BITSLIP   (BITSLIP),
    .BUSY      (BUSY),
    .LOCKED    (LOCKED),
    .FAIL      (FAIL),
    .SLIP_COUNT(SLIP_COUNT)
  );

  initial CLKDIV = 1'b0;
  always #5 CLKDIV = ~CLKDIV;

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    int m;
    m = n % 8;
    if (m == 0) return x;
    return (x << m) | (x >> (8 - m));
  endfunction

  always @(posedge CLKDIV) begin
    #1;
    if (mode == 1) begin
      if (BITSLIP === 1'b1) off = (off + 7) % 8;
      DATA_IN = rotl(P, off);
    end
  end

  task automatic tick();
    @(posedge CLKDIV);
    #1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    START = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    n_checks++;
    if ({SERDES_RST, BITSLIP, BUSY, LOCKED, FAIL} !== 5'b10000)
      $display("FAIL reset_flags got=%b want=10000", {SERDES_RST, BITSLIP, BUSY, LOCKED, FAIL});
    else n_pass++;
    n_checks++;
    if (SLIP_COUNT !== 4'd0) $display("FAIL reset_slip_count got=%0d want=0", SLIP_COUNT);
    else n_pass++;
    // START coincident with RST must be discarded.
    RST = 1'b1;
    START = 1'b1;
    tick();
    RST = 1'b0;
    START = 1'b0;
    tick();
    tick();
    tick();
    n_checks++;
    if (BUSY !== 1'b0 || SERDES_RST !== 1'b1)
      $display("FAIL reset_start_discard busy=%b srst=%b want busy=0 srst=1", BUSY, SERDES_RST);
    else n_pass++;
  endtask

  task automatic test_aligned();
    mode = 0;
    DATA_IN = P;
    pulse_start();
    for (int i = 1; i <= 12 + MC + 1; i++) begin
      if (i == 7) START = 1'b0;
      tick();
      if (i == 6) START = 1'b1;
      if (i == 1) begin
        n_checks++;
        if (BUSY !== 1'b1 || SERDES_RST !== 1'b1)
          $display("FAIL aligned_srst_entry busy=%b srst=%b want 1 1", BUSY, SERDES_RST);
        else n_pass++;
      end
      if (i == 3) begin
        n_checks++;
        if (SERDES_RST !== 1'b1) $display("FAIL aligned_srst_hold got=%b want=1", SERDES_RST);
        else n_pass++;
      end
      if (i == 4) begin
        n_checks++;
        if (SERDES_RST !== 1'b0) $display("FAIL aligned_srst_release got=%b want=0", SERDES_RST);
        else n_pass++;
      end
      if (i == 12 + MC) begin
        n_checks++;
        if (LOCKED !== 1'b0) $display("FAIL aligned_lock_early got=%b want=0", LOCKED);
        else n_pass++;
      end
    end
    n_checks++;
    if (LOCKED !== 1'b1 || BUSY !== 1'b0 || SLIP_COUNT !== 4'd0)
      $display("FAIL aligned_lock locked=%b busy=%b slips=%0d want 1 0 0", LOCKED, BUSY, SLIP_COUNT);
    else n_pass++;
  endtask

  task automatic test_monitor();
    logic [7:0] seq [8];
    seq = '{8'hFF, 8'hFF, 8'hFF, P, 8'hFF, 8'hFF, 8'hFF, P};
    mode = 0;
    for (int i = 0; i < 8; i++) begin
      DATA_IN = seq[i];
      tick();
    end
    n_checks++;
    if (LOCKED !== 1'b1) $display("FAIL monitor_short_runs got=%b want=1", LOCKED);
    else n_pass++;
    DATA_IN = 8'hFF;
    tick();
    tick();
    tick();
    n_checks++;
    if (LOCKED !== 1'b1) $display("FAIL monitor_three_miss got=%b want=1", LOCKED);
    else n_pass++;
    tick();
`ifdef SERDES_ALIGN_MONITOR_EN
    n_checks++;
    if (LOCKED !== 1'b0 || SERDES_RST !== 1'b1)
      $display("FAIL monitor_loss locked=%b srst=%b want 0 1", LOCKED, SERDES_RST);
    else n_pass++;
`else
    n_checks++;
    if (LOCKED !== 1'b1 || SERDES_RST !== 1'b0)
      $display("FAIL monitor_hold locked=%b srst=%b want 1 0", LOCKED, SERDES_RST);
    else n_pass++;
`endif
    DATA_IN = P;
    for (int i = 0; i < 12 + MC + 1; i++) tick();
    n_checks++;
    if (LOCKED !== 1'b1 || SLIP_COUNT !== 4'd0)
      $display("FAIL monitor_after locked=%b slips=%0d want 1 0", LOCKED, SLIP_COUNT);
    else n_pass++;
  endtask

  task automatic test_rotation(input int k);
    int pulses;
    int last;
    int lock_at;
    int want_at;
    mode = 1;
    off = k;
    DATA_IN = rotl(P, k);
    pulse_start();
    pulses = 0;
    last = -100;
    lock_at = -1;
    for (int i = 1; i <= 300 && lock_at < 0; i++) begin
      tick();
      if (BITSLIP === 1'b1) begin
        pulses++;
        if (pulses > 1) begin
          n_checks++;
          if (i - last < SW + 2)
            $display("FAIL rot_gap got=%0d want>=%0d", i - last, SW + 2);
          else n_pass++;
        end
        last = i;
      end
      if (LOCKED === 1'b1) lock_at = i;
    end
    // Each slip costs the pulse, the hold-off and one fresh compare.
    want_at = 12 + MC + 1 + k * (SW + 2);
    n_checks++;
    if (lock_at != want_at) $display("FAIL rot_lock_time k=%0d got=%0d want=%0d", k, lock_at, want_at);
    else n_pass++;
    n_checks++;
    if (pulses != k) $display("FAIL rot_pulses k=%0d got=%0d want=%0d", k, pulses, k);
    else n_pass++;
    n_checks++;
    if (SLIP_COUNT !== 4'(k)) $display("FAIL rot_slip_count got=%0d want=%0d", SLIP_COUNT, k);
    else n_pass++;
  endtask

  task automatic test_fail();
    int pulses;
    int fail_at;
    mode = 0;
    DATA_IN = 8'h00;
    pulse_start();
    pulses = 0;
    fail_at = -1;
    for (int i = 1; i <= 300 && fail_at < 0; i++) begin
      tick();
      if (BITSLIP === 1'b1) pulses++;
      if (LOCKED === 1'b1 && BUSY === 1'b1) begin
        n_checks++;
        $display("FAIL fail_locked_busy locked=%b busy=%b", LOCKED, BUSY);
      end
      if (FAIL === 1'b1) fail_at = i;
    end
    n_checks++;
    if (fail_at != 13 + DW * (SW + 2)) $display("FAIL fail_time got=%0d want=%0d", fail_at, 13 + DW * (SW + 2));
    else n_pass++;
    n_checks++;
    if (pulses != DW) $display("FAIL fail_pulses got=%0d want=%0d", pulses, DW);
    else n_pass++;
    repeat (5) tick();
    n_checks++;
    if (FAIL !== 1'b1 || LOCKED !== 1'b0 || BUSY !== 1'b0 || SLIP_COUNT !== 4'(DW))
      $display("FAIL fail_status fail=%b locked=%b busy=%b slips=%0d want 1 0 0 %0d",
               FAIL, LOCKED, BUSY, SLIP_COUNT, DW);
    else n_pass++;
  endtask

  task automatic test_reset_midslip();
    int pulses;
    mode = 1;
    off = 5;
    DATA_IN = rotl(P, 5);
    pulse_start();
    pulses = 0;
    for (int i = 0; i < 100 && pulses < 2; i++) begin
      tick();
      if (BITSLIP === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 2) $display("FAIL midslip_reach got=%0d want=2", pulses);
    else n_pass++;
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    n_checks++;
    if (SLIP_COUNT !== 4'd0 || BITSLIP !== 1'b0 || SERDES_RST !== 1'b1 || BUSY !== 1'b0)
      $display("FAIL midslip_reset slips=%0d bitslip=%b srst=%b busy=%b want 0 0 1 0",
               SLIP_COUNT, BITSLIP, SERDES_RST, BUSY);
    else n_pass++;
    mode = 0;
    DATA_IN = P;
    pulse_start();
    for (int i = 0; i < 12 + MC + 1; i++) tick();
    n_checks++;
    if (LOCKED !== 1'b1 || SLIP_COUNT !== 4'd0)
      $display("FAIL midslip_realign locked=%b slips=%0d want 1 0", LOCKED, SLIP_COUNT);
    else n_pass++;
  endtask

  initial begin
    RST = 1'b1;
    START = 1'b0;
    DATA_IN = 8'h00;
    test_reset();
    test_aligned();
    test_monitor();
    test_rotation(3);
    for (int r = 0; r < 3; r++) test_rotation(int'($urandom_range(0, 7)));
    test_fail();
    test_reset_midslip();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/serdes_bitslip_ctrl.md
SERDES_BITSLIP_CTRL -- requirements
Module: serdes_bitslip_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, giving the ISERDES word width (legal values 2..8).
REQ-002 The block SHALL have parameter TRAIN_PATTERN, default 8'h5C, giving the expected training word; only the DATA_WIDTH LSBs are compared.
REQ-003 The block SHALL have parameter MATCH_COUNT, default 4, giving the consecutive matching words required to declare lock (1..15).
REQ-004 The block SHALL have parameter SLIP_WAIT, default 3, giving the CLKDIV cycles to hold off after each BITSLIP pulse (1..15).
REQ-005 The block SHALL have parameter LOSS_THRESH, default 4, giving the consecutive mismatches that declare lock loss (1..15).
REQ-006 CLKDIV  input  1  divided SERDES clock; all logic is clocked on its rising edge.
REQ-007 RST  input  1  reset, synchronous, active-high; clock CLKDIV.
REQ-008 START  input  1  single-cycle request to begin alignment.
REQ-009 DATA_IN  input  8  parallel ISERDES word, Q1..Q8 order, LSB-aligned.
REQ-010 SERDES_RST  output  1  reset to the ISERDES/OSERDES pair.
REQ-011 BITSLIP  output  1  single-cycle bitslip pulse to the ISERDES.
REQ-012 BUSY  output  1  high in every state except IDLE, LOCKED and FAIL.
REQ-013 LOCKED  output  1  word alignment achieved.
REQ-014 FAIL  output  1  alignment impossible after DATA_WIDTH slips.
REQ-015 SLIP_COUNT  output  4  number of BITSLIP pulses issued in the current attempt.

Function
REQ-016 The FSM SHALL have the states IDLE, SRST, SETTLE, CHECK, SLIP, SWAIT, LOCKED and FAIL.
REQ-017 IDLE: SERDES_RST=1; START moves the FSM to SRST and clears SLIP_COUNT and the match counter.
REQ-018 SRST: SERDES_RST=1 for exactly 4 cycles, then SETTLE.
REQ-019 SETTLE: SERDES_RST=0 for 8 cycles, then CHECK.
REQ-020 CHECK: a DATA_IN match increments the match counter; reaching MATCH_COUNT moves the FSM to LOCKED on the next edge.
REQ-021 CHECK: a mismatch clears the match counter; with SLIP_COUNT < DATA_WIDTH the FSM goes to SLIP, otherwise to FAIL.
REQ-022 SLIP: BITSLIP=1 for exactly one cycle, SLIP_COUNT increments, then SWAIT.
REQ-023 SWAIT: BITSLIP=0 for SLIP_WAIT cycles; DATA_IN is ignored; then CHECK.
REQ-024 LOCKED/FAIL: LOCKED or FAIL is held high and SLIP_COUNT is frozen; START re-enters SRST with counters cleared.
REQ-025 START SHALL be ignored while BUSY=1.
REQ-026 BITSLIP SHALL never be high in two consecutive cycles; at least SLIP_WAIT+1 low cycles separate pulses.
REQ-027 LOCKED and FAIL SHALL be mutually exclusive and low whenever BUSY=1.
REQ-028 SLIP_COUNT SHALL never exceed DATA_WIDTH and SHALL not wrap.
REQ-029 All outputs SHALL be registered, with no combinational input-to-output path.

Reset
REQ-030 RST takes priority over every other input at the same edge, including mid-alignment.
REQ-031 On RST: state=IDLE, SERDES_RST=1, BITSLIP=0, BUSY=0, LOCKED=0, FAIL=0, SLIP_COUNT=0, all internal counters=0.
REQ-032 A START sampled in the same cycle as RST SHALL be discarded.

Configuration
REQ-033 Macro SERDES_ALIGN_MONITOR_EN SHALL enable lock-loss monitoring.
REQ-034 With SERDES_ALIGN_MONITOR_EN defined: in LOCKED, LOSS_THRESH consecutive mismatches deassert LOCKED and enter SRST with counters cleared (automatic re-alignment); any match resets the loss counter.
REQ-035 Without SERDES_ALIGN_MONITOR_EN: LOCKED is held until RST or START, DATA_IN is ignored in LOCKED, and no loss-counter logic is synthesised.

Verification
REQ-036 DATA_IN=8'h5C constant, START pulse -> SERDES_RST high 4 cycles, low; LOCKED=1 with SLIP_COUNT=0 exactly 12+MATCH_COUNT+1 cycles after START.
REQ-037 Word stream 8'h5C rotated by 3 bits, model applies one rotation per BITSLIP -> exactly 3 BITSLIP pulses, each followed by 3 low cycles, then LOCKED=1 with SLIP_COUNT=3.
REQ-038 DATA_IN=8'h00 constant -> 8 BITSLIP pulses, then FAIL=1, LOCKED=0, SLIP_COUNT=8, BUSY=0.
REQ-039 RST asserted for 1 cycle while in SWAIT after 2 slips -> next cycle state IDLE, SLIP_COUNT=0, BITSLIP=0, SERDES_RST=1; a later START realigns normally.
REQ-040 Macro defined, LOCKED, then DATA_IN forced to 8'hFF for 4 cycles -> LOCKED falls and SERDES_RST rises on the next edge; macro undefined, same stimulus -> LOCKED stays 1.
